// File: rtl/tl_resp_checker_if.sv
// rtl/tl_resp_checker_if.sv - TileLink D-channel signal bundle shared by master, slave and observers
interface tl_resp_checker_if #(
  parameter int DATA_W = 64
) ();
  logic              d_valid;
  logic              d_ready;
  logic [DATA_W-1:0] d_data;

  modport master  (output d_valid, output d_data, input d_ready);
  modport slave   (input d_valid, input d_data, output d_ready);
  // Observe-only tap: the checker never drives the bus.
  modport monitor (input d_valid, input d_ready, input d_data);
endinterface

// File: rtl/tl_resp_checker.sv
// rtl/tl_resp_checker.sv - TileLink D-channel response checker against a loadable expected-beat table
// Optional TL_RESP_CHECK_SVA_EN adds per-beat match and stall assertions.
module tl_resp_checker #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  tl_resp_checker_if.monitor  dch,
  input  logic                exp_we,
  input  logic [IDX_W-1:0]    exp_addr,
  input  logic [DATA_W-1:0]   exp_data,
  input  logic [DATA_W-1:0]   cmp_mask,
  input  logic                start,
  input  logic [IDX_W:0]      num_beats,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CNT_W-1:0]    err_count,
  output logic [IDX_W-1:0]    err_index,
  output logic [DATA_W-1:0]   err_data
);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   last_idx;
  logic [DATA_W-1:0]  mask_q;
  logic [TMR_W-1:0]   timer;
  logic               err_seen;
  logic [DATA_W-1:0]  exp_mem [DEPTH];

  logic               beat;
  logic               mismatch;
  logic               tmr_expire;
  logic [IDX_W:0]     nb_eff;
  logic [IDX_W-1:0]   last_start;

  assign beat     = dch.d_valid & dch.d_ready;
  assign mismatch = |((dch.d_data ^ exp_mem[idx]) & mask_q);

  // Out-of-range beat counts fall back to a full-table run.
  always_comb begin
    nb_eff = num_beats;
    if (num_beats == '0 || num_beats > (IDX_W+1)'(DEPTH)) begin
      nb_eff = (IDX_W+1)'(DEPTH);
    end
  end

  assign last_start = IDX_W'(nb_eff - (IDX_W+1)'(1));

  generate
    if (TIMEOUT > 0) begin : g_timer
      assign tmr_expire = (timer == TMR_W'(TIMEOUT - 1));
    end else begin : g_no_timer
      assign tmr_expire = 1'b0;
    end
  endgenerate

  // Table is only writable while idle so a run always sees a stable reference.
  always_ff @(posedge clk) begin
    if (exp_we && state == S_IDLE) begin
      exp_mem[exp_addr] <= exp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
      err_index <= '0;
      err_data  <= '0;
      err_seen  <= 1'b0;
      idx       <= '0;
      last_idx  <= '0;
      mask_q    <= '0;
      timer     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            err_index <= '0;
            err_data  <= '0;
            err_seen  <= 1'b0;
            idx       <= '0;
            timer     <= '0;
            mask_q    <= cmp_mask;
            last_idx  <= last_start;
          end
        end
        S_RUN: begin
          // A beat on the expiry cycle takes priority over the timeout.
          if (beat) begin
            timer <= '0;
            idx   <= idx + IDX_W'(1);
            if (mismatch) begin
              if (!err_seen) begin
                err_seen  <= 1'b1;
                err_index <= idx;
                err_data  <= dch.d_data;
              end
              if (err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
              end
            end
            if (idx == last_idx) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (tmr_expire) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pass = done & (err_count == '0) & ~timeout;

`ifdef TL_RESP_CHECK_SVA_EN
  a_beat_match: assert property (
    @(posedge clk) disable iff (rst)
    (state == S_RUN && beat) |-> !mismatch
  ) else $error("%0t tl_resp_checker: beat %0d got %h expected %h mask %h",
                $time, idx, dch.d_data, exp_mem[idx], mask_q);

  generate
    if (TIMEOUT > 0) begin : g_stall_sva
      a_no_stall: assert property (
        @(posedge clk) disable iff (rst)
        not ((busy && !beat) [*TIMEOUT+1])
      );
    end
  endgenerate
`else
  // Checks compiled out; counters and status outputs behave identically.
`endif

endmodule

// File: tb/tb_tl_resp_checker.sv
// tb/tb_tl_resp_checker.sv - randomized self-checking bench for tl_resp_checker
module tb_tl_resp_checker;
  localparam int DATA_W  = 64;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 2;
  localparam int IDX_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tl_resp_checker_if #(.DATA_W(DATA_W)) dch ();

  logic              exp_we;
  logic [IDX_W-1:0]  exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] cmp_mask;
  logic              start;
  logic [IDX_W:0]    num_beats;
  logic              busy, done, pass, timeout;
  logic [CNT_W-1:0]  err_count;
  logic [IDX_W-1:0]  err_index;
  logic [DATA_W-1:0] err_data;

  tl_resp_checker #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .dch(dch),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .cmp_mask(cmp_mask), .start(start), .num_beats(num_beats),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .err_index(err_index), .err_data(err_data)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] sb      [DEPTH];
  logic [63:0] beat_d  [DEPTH];
  int          stall_n [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    dch.d_valid = 1'b0;
    dch.d_ready = 1'b0;
    dch.d_data  = rnd64();
    exp_we      = 1'b0;
    start       = 1'b0;
  endtask

  // Never a beat; also throws in table writes and starts that must be ignored while running.
  task automatic stall_cycle(input bit vr_only);
    int sel;
    sel = vr_only ? 0 : int'($urandom % 3);
    dch.d_valid = (sel == 0);
    dch.d_ready = (sel == 1);
    dch.d_data  = rnd64();
    exp_we      = ($urandom % 4 == 0);
    exp_addr    = IDX_W'($urandom);
    exp_data    = rnd64();
    start       = ($urandom % 8 == 0);
    tick();
    quiet();
  endtask

  task automatic load_entry(input int i, input logic [63:0] v);
    exp_addr = IDX_W'(i);
    exp_data = v;
    exp_we   = 1'b1;
    tick();
    exp_we   = 1'b0;
    sb[i]    = v;
  endtask

  task automatic set_beats(input int stall_mode);
    for (int i = 0; i < DEPTH; i++) begin
      beat_d[i] = sb[i];
      case (stall_mode)
        0:       stall_n[i] = 0;
        1:       stall_n[i] = ($urandom % 4 == 0) ? 15 : int'($urandom % 4);
        default: stall_n[i] = 15;
      endcase
    end
  endtask

  task automatic do_run(input int n_req, input logic [63:0] mask, input int n_drive, input bit vr_only);
    int          n_eff;
    int          exp_cnt;
    int          first;
    logic [63:0] fdata;
    bit          exp_to;
    n_eff   = (n_req == 0 || n_req > DEPTH) ? DEPTH : n_req;
    exp_cnt = 0;
    first   = -1;
    fdata   = '0;
    num_beats = 5'(n_req);
    cmp_mask  = mask;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    for (int i = 0; i < n_drive; i++) begin
      for (int s = 0; s < stall_n[i]; s++) stall_cycle(vr_only);
      dch.d_valid = 1'b1;
      dch.d_ready = 1'b1;
      dch.d_data  = beat_d[i];
      tick();
      quiet();
      if (((beat_d[i] ^ sb[i]) & mask) != 0) begin
        if (first < 0) begin
          first = i;
          fdata = beat_d[i];
        end
        if (exp_cnt < CNT_MAX) exp_cnt++;
      end
      if (i == 0 && n_eff > 1) check("busy_mid_run", {63'd0, busy}, 64'd1);
    end
    exp_to = (n_drive < n_eff);
    if (exp_to) begin
      for (int j = 0; j < TIMEOUT; j++) begin
        stall_cycle(1'b0);
        if (j == TIMEOUT - 2) check("no_early_timeout", {63'd0, done}, 64'd0);
      end
    end
    check("done",      {63'd0, done},    64'd1);
    check("busy_end",  {63'd0, busy},    64'd0);
    check("timeout",   {63'd0, timeout}, {63'd0, exp_to});
    check("pass",      {63'd0, pass},    {63'd0, (exp_cnt == 0) && !exp_to});
    check("err_count", {62'd0, err_count}, 64'(exp_cnt));
    check("err_index", {60'd0, err_index}, (first < 0) ? 64'd0 : 64'(first));
    check("err_data",  err_data, fdata);
    dch.d_valid = 1'b1;
    dch.d_ready = 1'b1;
    dch.d_data  = ~sb[0];
    tick();
    quiet();
    check("done_beat_ignored", {62'd0, err_count}, 64'(exp_cnt));
    check("done_held",         {63'd0, done},      64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    {63'd0, busy},    64'd0);
    check({tag, "_done"},    {63'd0, done},    64'd0);
    check({tag, "_pass"},    {63'd0, pass},    64'd0);
    check({tag, "_timeout"}, {63'd0, timeout}, 64'd0);
    check({tag, "_errcnt"},  {62'd0, err_count}, 64'd0);
    check({tag, "_erridx"},  {60'd0, err_index}, 64'd0);
    check({tag, "_errdata"}, err_data, 64'd0);
  endtask

  initial begin
    logic [63:0] prog [7];
    prog[0] = 64'h000015b7f1402573;
    prog[1] = 64'h0000000002028593;
    prog[2] = 64'h0000001f0182b283;
    prog[3] = 64'h00000000000000b7;
    prog[4] = 64'h0000000010500073;
    prog[5] = 64'h0000000000004505;
    prog[6] = 64'h0000000000008282;

    quiet();
    exp_addr  = '0;
    exp_data  = '0;
    cmp_mask  = '0;
    num_beats = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < 7; i++) load_entry(i, prog[i]);
    for (int i = 7; i < DEPTH; i++) load_entry(i, rnd64());

    // A beat while idle must not advance anything.
    dch.d_valid = 1'b1;
    dch.d_ready = 1'b1;
    dch.d_data  = rnd64();
    tick();
    quiet();

    set_beats(0);
    do_run(7, '1, 7, 1'b0);

    beat_d[3] = sb[3] ^ 64'h1;
    do_run(7, '1, 7, 1'b0);
    do_run(7, ~64'h1, 7, 1'b0);

    set_beats(0);
    stall_n[0] = 5;
    stall_n[1] = 2;
    stall_n[4] = 3;
    do_run(7, '1, 7, 1'b1);

    set_beats(0);
    do_run(4, '1, 2, 1'b0);
    do_run(5, '1, 0, 1'b0);

    set_beats(2);
    do_run(3, '1, 3, 1'b0);

    set_beats(0);
    for (int i = 0; i < DEPTH; i++) beat_d[i] = sb[i] ^ (64'h1 << (i * 3));
    do_run(6, '1, 6, 1'b0);

    set_beats(0);
    do_run(0, '1, 16, 1'b0);
    do_run(16, '1, 16, 1'b0);
    do_run(20, '1, 16, 1'b0);

    // Abort mid-run after three mismatching beats, with table writes attempted during the run.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    num_beats = 5'd8;
    cmp_mask  = '1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dch.d_valid = 1'b1;
      dch.d_ready = 1'b1;
      dch.d_data  = ~sb[i];
      exp_we      = 1'b1;
      exp_addr    = IDX_W'(i);
      exp_data    = rnd64();
      tick();
      quiet();
    end
    check("pre_rst_errcnt", {62'd0, err_count}, 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrun_rst");
    set_beats(0);
    do_run(5, '1, 5, 1'b0);

    for (int iter = 0; iter < 40; iter++) begin
      int          n_req;
      int          n_eff;
      int          n_drive;
      logic [63:0] mask;
      if ($urandom % 8 == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("loop_rst_errcnt", {62'd0, err_count}, 64'd0);
        for (int i = 0; i < DEPTH; i++) load_entry(i, rnd64());
      end
      n_req   = int'($urandom % 32);
      n_eff   = (n_req == 0 || n_req > DEPTH) ? DEPTH : n_req;
      n_drive = ($urandom % 4 == 0) ? int'($urandom % n_eff) : n_eff;
      mask    = ($urandom % 2 == 0) ? '1 : rnd64();
      set_beats(1);
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom % 3 == 0) beat_d[i] = sb[i] ^ (64'h1 << ($urandom % 64));
      end
      do_run(n_req, mask, n_drive, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
